// File: rtl/game_phase_ctrl.sv
// Game sequencer: PRELIM countdown -> GAME symbol stream -> ANSWER window -> POST result,
// with LOST as the terminal state until restart. Every output is a register.
module game_phase_ctrl #(
  parameter int PRELIM_SECS    = 5,
  parameter int ANSWER_SECS    = 10,
  parameter int POST_SECS      = 4,
  parameter int BASE_SYMBOLS   = 10,
  parameter int SYMS_PER_LEVEL = 2,
  parameter int MAX_LEVEL      = 31,
  parameter int MAX_DIFF       = 3
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Tick1Hz,
  input  logic       TickGen,
  input  logic       start,
  input  logic       answerSubmit,
  input  logic [6:0] userCount,
  input  logic [6:0] gameCount,
  output logic       prelimPeriod,
  output logic       gamePeriod,
  output logic       answerPeriod,
  output logic       postPeriod,
  output logic       symStep,
  output logic [3:0] countDownTime,
  output logic [4:0] level,
  output logic [6:0] countDifference,
  output logic       lose
);

  typedef enum logic [2:0] {IDLE, PRELIM, GAME, ANSWER, POST, LOST} phaseT;

  phaseT      state, stateNext;
  logic [6:0] symLeft, symLeftNext;
  logic [3:0] cdtNext;
  logic [4:0] levelNext;
  logic [6:0] diffNext, diffNow;
  logic       loseNext, symStepNext;
  logic       prelimNext, gameNext, answerNext, postNext;

  // Symbols for a level grow linearly and are clipped to what the display can show.
  function automatic logic [6:0] symLoad(input logic [4:0] lv);
    int n;
    n = BASE_SYMBOLS + (int'(lv) - 1) * SYMS_PER_LEVEL;
    return (n > 99) ? 7'd99 : 7'(n);
  endfunction

  function automatic logic [6:0] absDiff(input logic [6:0] a, input logic [6:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [4:0] levelInc(input logic [4:0] lv);
    return (lv >= 5'(MAX_LEVEL)) ? 5'(MAX_LEVEL) : (lv + 5'd1);
  endfunction

  assign diffNow = absDiff(userCount, gameCount);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state           <= IDLE;
      symLeft         <= 7'd0;
      countDownTime   <= 4'd0;
      level           <= 5'd1;
      countDifference <= 7'd0;
      lose            <= 1'b0;
      symStep         <= 1'b0;
      prelimPeriod    <= 1'b0;
      gamePeriod      <= 1'b0;
      answerPeriod    <= 1'b0;
      postPeriod      <= 1'b0;
    end else begin
      state           <= stateNext;
      symLeft         <= symLeftNext;
      countDownTime   <= cdtNext;
      level           <= levelNext;
      countDifference <= diffNext;
      lose            <= loseNext;
      symStep         <= symStepNext;
      prelimPeriod    <= prelimNext;
      gamePeriod      <= gameNext;
      answerPeriod    <= answerNext;
      postPeriod      <= postNext;
    end
  end

  always_comb begin
    stateNext   = state;
    symLeftNext = symLeft;
    cdtNext     = countDownTime;
    levelNext   = level;
    diffNext    = countDifference;
    loseNext    = lose;
    symStepNext = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          stateNext = PRELIM;
          cdtNext   = 4'(PRELIM_SECS);
        end
      end
      PRELIM: begin
        if (Tick1Hz) begin
          if (countDownTime == 4'd1) begin
            stateNext   = GAME;
            cdtNext     = 4'd0;
            symLeftNext = symLoad(level);
          end else begin
            cdtNext = countDownTime - 4'd1;
          end
        end
      end
      GAME: begin
        if (TickGen && (symLeft != 7'd0)) begin
          symStepNext = 1'b1;
          symLeftNext = symLeft - 7'd1;
          if (symLeft == 7'd1) begin
            stateNext = ANSWER;
            cdtNext   = 4'(ANSWER_SECS);
          end
        end
      end
      ANSWER: begin
        // Submit and timeout share one transition, so coinciding pulses act as one.
        if (answerSubmit || (Tick1Hz && (countDownTime == 4'd1))) begin
          stateNext = POST;
          diffNext  = diffNow;
          loseNext  = (diffNow > 7'(MAX_DIFF));
          cdtNext   = 4'(POST_SECS);
        end else if (Tick1Hz) begin
          cdtNext = countDownTime - 4'd1;
        end
      end
      POST: begin
        if (Tick1Hz) begin
          if (countDownTime == 4'd1) begin
            if (lose) begin
              stateNext = LOST;
              cdtNext   = 4'd0;
            end else begin
              stateNext = PRELIM;
              levelNext = levelInc(level);
              cdtNext   = 4'(PRELIM_SECS);
            end
          end else begin
            cdtNext = countDownTime - 4'd1;
          end
        end
      end
      LOST: begin
        if (start) begin
          stateNext = PRELIM;
          levelNext = 5'd1;
          loseNext  = 1'b0;
          diffNext  = 7'd0;
          cdtNext   = 4'(PRELIM_SECS);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Flags are decoded from the upcoming state so they land in the same cycle as it.
  always_comb begin
    prelimNext = (stateNext == PRELIM);
    gameNext   = (stateNext == GAME);
    answerNext = (stateNext == ANSWER);
    postNext   = (stateNext == POST) || (stateNext == LOST);
  end

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Directed bench for game_phase_ctrl: walks every phase, level saturation, loss and mid-game reset.
module tb_game_phase_ctrl;
  logic       Clk = 1'b0;
  logic       Rst_n, Tick1Hz, TickGen, start, answerSubmit;
  logic [6:0] userCount, gameCount;
  logic       prelimPeriod, gamePeriod, answerPeriod, postPeriod, symStep, lose;
  logic [3:0] countDownTime;
  logic [4:0] level;
  logic [6:0] countDifference;

  int checks = 0;
  int failures = 0;
  int expLevel;

  game_phase_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n), .Tick1Hz(Tick1Hz), .TickGen(TickGen), .start(start),
    .answerSubmit(answerSubmit), .userCount(userCount), .gameCount(gameCount),
    .prelimPeriod(prelimPeriod), .gamePeriod(gamePeriod), .answerPeriod(answerPeriod),
    .postPeriod(postPeriod), .symStep(symStep), .countDownTime(countDownTime),
    .level(level), .countDifference(countDifference), .lose(lose)
  );

  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle pulse on any combination of the strobes; returns at the sampling negedge after the edge.
  task automatic pulse(input logic sec, input logic gen, input logic sub, input logic st);
    @(negedge Clk);
    Tick1Hz = sec; TickGen = gen; answerSubmit = sub; start = st;
    @(negedge Clk);
    Tick1Hz = 1'b0; TickGen = 1'b0; answerSubmit = 1'b0; start = 1'b0;
  endtask

  task automatic checkFlags(input string tag, input logic [3:0] exp);
    checkVal(tag, {prelimPeriod, gamePeriod, answerPeriod, postPeriod}, exp);
  endtask

  // Streams TickGen pulses until ANSWER, returning the number of symStep pulses seen.
  task automatic streamSyms(output int n);
    n = 0;
    for (int i = 0; i < 200 && !answerPeriod; i++) begin
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      if (symStep) n++;
    end
  endtask

  // From PRELIM at full countdown: play one level and pass it with difference diff.
  task automatic passLevel(input int syms, input logic coincide, input int diff);
    int n;
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checkFlags("lvl_game", 4'b0100);
    streamSyms(n);
    checkVal("lvl_syms", n, syms);
    checkVal("lvl_ans_cdt", countDownTime, 10);
    gameCount = 7'(syms);
    userCount = 7'(syms + diff);
    if (coincide) begin
      for (int i = 0; i < 9; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
      checkVal("lvl_cdt1", countDownTime, 1);
      pulse(1'b1, 1'b0, 1'b1, 1'b0);
    end else begin
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
    end
    checkFlags("lvl_post", 4'b0001);
    checkVal("lvl_diff", countDifference, diff);
    checkVal("lvl_lose", lose, 0);
    checkVal("lvl_post_cdt", countDownTime, 4);
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    expLevel = (expLevel < 31) ? expLevel + 1 : 31;
    checkFlags("lvl_prelim", 4'b1000);
    checkVal("lvl_level", level, expLevel);
    checkVal("lvl_pre_cdt", countDownTime, 5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got 0 expected 1 (bench did not finish)");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    Rst_n = 1'b0; Tick1Hz = 1'b0; TickGen = 1'b0; start = 1'b0; answerSubmit = 1'b0;
    userCount = 7'd0; gameCount = 7'd0;
    repeat (2) @(negedge Clk);
    checkFlags("rst_flags", 4'b0000);
    checkVal("rst_cdt", countDownTime, 0);
    checkVal("rst_level", level, 1);
    checkVal("rst_diff", countDifference, 0);
    checkVal("rst_lose", lose, 0);
    checkVal("rst_step", symStep, 0);
    Rst_n = 1'b1;

    // Ticks in IDLE are ignored
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    checkFlags("idle_ticks", 4'b0000);
    checkVal("idle_step", symStep, 0);

    // Preliminary countdown
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    checkFlags("pre_flags", 4'b1000);
    checkVal("pre_cdt", countDownTime, 5);
    for (int i = 1; i <= 4; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      checkVal("pre_cdt_step", countDownTime, 5 - i);
      checkFlags("pre_hold", 4'b1000);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checkFlags("game_enter", 4'b0100);
    checkVal("game_cdt", countDownTime, 0);

    // Level-1 stream, with a coincident Tick1Hz and a start that must both be ignored
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    checkFlags("game_ign", 4'b0100);
    checkVal("game_ign_cdt", countDownTime, 0);
    checkVal("game_ign_step", symStep, 0);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      pulse((i == 3), 1'b1, 1'b0, 1'b0);
      checkVal("game_step_hi", symStep, 1);
      n++;
      if (i < 10) checkFlags("game_hold", 4'b0100);
    end
    checkFlags("ans_enter", 4'b0010);
    checkVal("ans_cdt", countDownTime, 10);
    @(negedge Clk);
    checkVal("step_one_cycle", symStep, 0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    checkVal("ans_no_step", symStep, 0);

    // Submitted answer, difference 2 -> pass
    userCount = 7'd12; gameCount = 7'd10;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("ans_dec", countDownTime, 9);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    checkFlags("post_flags", 4'b0001);
    checkVal("post_diff", countDifference, 2);
    checkVal("post_lose", lose, 0);
    checkVal("post_cdt", countDownTime, 4);
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("post_cdt1", countDownTime, 1);
    checkFlags("post_hold", 4'b0001);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checkFlags("l2_prelim", 4'b1000);
    checkVal("l2_level", level, 2);
    checkVal("l2_cdt", countDownTime, 5);
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    streamSyms(n);
    checkVal("l2_syms", n, 12);

    // Timeout with difference 7 -> loss
    userCount = 7'd3; gameCount = 7'd10;
    for (int i = 0; i < 9; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("to_cdt1", countDownTime, 1);
    checkFlags("to_ans", 4'b0010);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checkFlags("to_post", 4'b0001);
    checkVal("to_diff", countDifference, 7);
    checkVal("to_lose", lose, 1);
    checkVal("to_cdt", countDownTime, 4);
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checkFlags("lost_flags", 4'b0001);
    checkVal("lost_cdt", countDownTime, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      pulse(1'b1, 1'b1, 1'b1, 1'b0);
      if (symStep || !postPeriod || !lose || countDownTime != 4'd0) n++;
    end
    checkVal("lost_stay", n, 0);
    checkVal("lost_level", level, 2);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    checkFlags("restart_flags", 4'b1000);
    checkVal("restart_level", level, 1);
    checkVal("restart_lose", lose, 0);
    checkVal("restart_diff", countDifference, 0);
    checkVal("restart_cdt", countDownTime, 5);

    // Climb to the level ceiling; symbol loads follow min(10+2*(lv-1), 99)
    expLevel = 1;
    for (int lv = 1; lv <= 30; lv++) passLevel(10 + 2 * (lv - 1), 1'b0, lv % 4);
    checkVal("max_level", level, 31);
    // Pass at the ceiling with submit and timeout together, difference exactly MAX_DIFF
    passLevel(70, 1'b1, 3);
    checkVal("max_level_hold", level, 31);

    // Reset in the middle of a symbol stream
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    checkFlags("mid_game", 4'b0100);
    @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    checkFlags("mid_rst_flags", 4'b0000);
    checkVal("mid_rst_level", level, 1);
    checkVal("mid_rst_step", symStep, 0);
    checkVal("mid_rst_cdt", countDownTime, 0);
    Rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      if (symStep) n++;
    end
    checkVal("post_rst_nostep", n, 0);
    checkFlags("post_rst_idle", 4'b0000);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    checkFlags("rerun_prelim", 4'b1000);
    checkVal("rerun_cdt", countDownTime, 5);
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checkFlags("rerun_game", 4'b0100);
    streamSyms(n);
    checkVal("rerun_syms", n, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_phase_ctrl.md
Name: game_phase_ctrl

Overview:
Top-level game sequencer that sits directly upstream of the display controller. It steps through the preliminary countdown, symbol stream, answer window and post-level phases. It drives the one-hot period flags, countdown time, level, score (count difference) and lose flag consumed by the display. It also issues the per-symbol step strobes to the symbol generator.

Parameters:
PRELIM_SECS, 5, length of the preliminary countdown in 1 Hz ticks (1..15)
ANSWER_SECS, 10, answer window length in 1 Hz ticks (1..15)
POST_SECS, 4, post-level display length in 1 Hz ticks (1..15)
BASE_SYMBOLS, 10, symbols streamed at level 1
SYMS_PER_LEVEL, 2, additional symbols per level above 1
MAX_LEVEL, 31, level saturation value
MAX_DIFF, 3, largest count difference that still passes a level

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
Tick1Hz  in  1  one-Clk-cycle pulse, once per second
TickGen  in  1  one-Clk-cycle pulse, symbol-rate tick
start  in  1  debounced one-cycle start/restart pulse
answerSubmit  in  1  one-cycle pulse, player confirms count
userCount  in  7  player's count (0..99)
gameCount  in  7  true symbol count from generator (0..99)
prelimPeriod  out  1  high during PRELIM
gamePeriod  out  1  high during GAME
answerPeriod  out  1  high during ANSWER
postPeriod  out  1  high during POST and LOST
symStep  out  1  one-cycle strobe: generator emits next symbol
countDownTime  out  4  remaining seconds in current timed phase
level  out  5  current level (1..MAX_LEVEL)
countDifference  out  7  |userCount-gameCount| latched at answer end
lose  out  1  high once the player has failed

Behaviour:
- Reset (async, Rst_n=0): state IDLE; all period flags 0; symStep 0; countDownTime 0; level 1; countDifference 0; lose 0; internal symLeft 0.
- All outputs are registered. A transition caused by an input in cycle N is visible in cycle N+1.
- Period flags: at most one is high in any cycle; none are high in IDLE.
- IDLE: on start, go to PRELIM and load countDownTime=PRELIM_SECS. Tick inputs are ignored.
- PRELIM:
  - Each Tick1Hz with countDownTime>1 decrements countDownTime.
  - A Tick1Hz with countDownTime==1 moves to GAME, sets countDownTime=0 and loads symLeft=BASE_SYMBOLS+(level-1)*SYMS_PER_LEVEL, saturated at 99.
  - PRELIM therefore lasts exactly PRELIM_SECS ticks.
- GAME:
  - Each TickGen with symLeft>0 pulses symStep in the next cycle (one cycle wide) and decrements symLeft.
  - The TickGen that takes symLeft from 1 to 0 also moves to ANSWER (with its symStep) and loads countDownTime=ANSWER_SECS.
  - Tick1Hz is ignored.
- ANSWER:
  - Tick1Hz decrements countDownTime.
  - On answerSubmit, or on a Tick1Hz with countDownTime==1 (timeout), move to POST.
  - On that same edge, latch countDifference=|userCount-gameCount| (7-bit unsigned, max 99), set lose=(difference>MAX_DIFF) and load countDownTime=POST_SECS.
  - If answerSubmit and the timeout tick coincide, the outcome is identical (single transition).
- POST:
  - Tick1Hz decrements countDownTime.
  - On expiry (tick with countDownTime==1), if lose=1, go to LOST with countDownTime=0.
  - Otherwise increment level (saturates at MAX_LEVEL; remains MAX_LEVEL on further passes), go to PRELIM and load countDownTime=PRELIM_SECS.
- LOST:
  - postPeriod and lose are held high. Ticks are ignored.
  - start restarts: level=1, lose=0, countDifference=0, go to PRELIM with countDownTime=PRELIM_SECS.
- start outside IDLE/LOST is ignored.
- Tick1Hz and TickGen arriving in the same cycle are each handled only by the state that uses them.
- Reset asserted mid-phase returns immediately to the reset values; no symStep is emitted after reset until the next GAME.

Test Plan:
1. Reset, start, 5 Tick1Hz -> prelimPeriod high with countDownTime 5,4,3,2,1, then gamePeriod=1 one cycle after the 5th tick, symLeft=10.
2. Level 1 GAME with 10 TickGen pulses -> exactly 10 one-cycle symStep pulses; answerPeriod=1 with countDownTime=10 one cycle after the 10th tick.
3. ANSWER with userCount=12, gameCount=10, answerSubmit -> postPeriod=1, countDifference=2, lose=0; after 4 Tick1Hz, level=2, prelimPeriod=1; the next GAME streams 12 symbols.
4. ANSWER with userCount=3, gameCount=10, no submit, 10 Tick1Hz -> POST with countDifference=7, lose=1; after 4 ticks stays in LOST (postPeriod=1) across 20 further ticks; start -> level=1, lose=0, prelimPeriod=1.
5. Force level=31 and pass a level -> level stays 31; symbol load =min(10+30*2, 99)=70.
6. Assert Rst_n=0 mid-GAME after 4 symStep pulses -> next cycle all flags 0, level=1, no further symStep; start again -> normal PRELIM countdown from 5.
